// File: rtl/genius_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : genius_sequencer_if
//  Description : Command/response bundle between the genius controller FSM
//                (master) and the genius_sequencer (slave).
//                master drives : START_1, START_2, GROW, CLEAR, R, B
//                slave drives  : END_1, END_2, B_OUT, ROUND_OK, MISS,
//                                TIMEOUT, LEN, FULL
//  Revision    : 1.0  initial release
// ============================================================================
interface genius_sequencer_if #(
  parameter int MAX_LEN = 32
);
  localparam int c_LEN_W = $clog2(MAX_LEN + 1);

  logic               START_1;
  logic               START_2;
  logic               GROW;
  logic               CLEAR;
  logic               R;
  logic [2:0]         B;
  logic               END_1;
  logic               END_2;
  logic [2:0]         B_OUT;
  logic               ROUND_OK;
  logic               MISS;
  logic               TIMEOUT;
  logic [c_LEN_W-1:0] LEN;
  logic               FULL;

  modport master (
    output START_1, START_2, GROW, CLEAR, R, B,
    input  END_1, END_2, B_OUT, ROUND_OK, MISS, TIMEOUT, LEN, FULL
  );

  modport slave (
    input  START_1, START_2, GROW, CLEAR, R, B,
    output END_1, END_2, B_OUT, ROUND_OK, MISS, TIMEOUT, LEN, FULL
  );
endinterface
`default_nettype wire

// File: rtl/genius_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : genius_sequencer
//  Description : Stores the growing Simon colour sequence, appends random
//                colours from a 16-bit Galois LFSR, plays the sequence back
//                on B_OUT (START_1 -> END_1) and checks player presses
//                against it (START_2 -> END_2 with ROUND_OK/MISS/TIMEOUT).
//  Ports       : CLK   - system clock, rising edge
//                RESET - asynchronous, active-low reset
//                bus   - genius_sequencer_if.slave command/response bundle
//  Revision    : 1.0  initial release
// ============================================================================
module genius_sequencer #(
  parameter int          MAX_LEN        = 32,
  parameter int          ON_CYCLES      = 4,
  parameter int          OFF_CYCLES     = 2,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  genius_sequencer_if.slave        bus
);

  localparam int c_LEN_W    = $clog2(MAX_LEN + 1);
  localparam int c_IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int c_PH_MAX   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int c_PH_W     = (c_PH_MAX > 1) ? $clog2(c_PH_MAX) : 1;
  localparam int c_TMR_W    = $clog2(TIMEOUT_CYCLES);

  localparam logic [15:0]        c_LFSR_MASK = 16'hB400;
  localparam logic [c_PH_W-1:0]  c_ON_LAST   = c_PH_W'(ON_CYCLES - 1);
  localparam logic [c_PH_W-1:0]  c_OFF_LAST  = c_PH_W'(OFF_CYCLES - 1);
  // The timer has counted TIMEOUT_CYCLES-2 idle edges; the next idle edge
  // would bring it to TIMEOUT_CYCLES-1, which is the expiry point.
  localparam logic [c_TMR_W-1:0] c_TMR_LAST  = c_TMR_W'(TIMEOUT_CYCLES - 2);
  localparam logic [c_LEN_W-1:0] c_LEN_ONE   = c_LEN_W'(1);
  localparam logic [c_LEN_W-1:0] c_LEN_PRE   = c_LEN_W'(MAX_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLAY_ON  = 3'd1,
    S_PLAY_OFF = 3'd2,
    S_LISTEN   = 3'd3,
    S_DONE1    = 3'd4,
    S_DONE2    = 3'd5
  } state_t;

  // 2-bit colour index -> 3-bit display code (GREEN, RED, BLUE, YELLOW)
  function automatic logic [2:0] f_colour_code(input logic [1:0] idx);
    logic [2:0] code;
    case (idx)
      2'd0:    code = 3'd2;
      2'd1:    code = 3'd3;
      2'd2:    code = 3'd4;
      default: code = 3'd6;
    endcase
    return code;
  endfunction

  state_t               r_state;
  logic [c_LEN_W-1:0]   r_len;
  logic                 r_full;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_PH_W-1:0]    r_ph_cnt;
  logic [c_TMR_W-1:0]   r_timer;
  logic [15:0]          r_lfsr;
  logic                 r_r_prev;
  logic [2:0]           r_b_out;
  logic                 r_end_1;
  logic                 r_end_2;
  logic                 r_round_ok;
  logic                 r_miss;
  logic                 r_timeout;
  logic [1:0]           r_mem [MAX_LEN];

  logic [15:0]          w_lfsr_next;
  logic [c_IDX_W-1:0]   w_idx_inc;
  logic [c_IDX_W-1:0]   w_wr_addr;
  logic                 w_last;
  logic                 w_press;
  logic                 w_hit;
  logic                 w_grow_fire;
  logic [2:0]           w_cur_code;
  logic [2:0]           w_next_code;
  logic [2:0]           w_first_code;

  assign w_lfsr_next  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_MASK : 16'h0000);
  assign w_idx_inc    = r_idx + c_IDX_W'(1);
  assign w_wr_addr    = r_len[c_IDX_W-1:0];
  assign w_last       = (c_LEN_W'(r_idx) == (r_len - c_LEN_ONE));
  assign w_press      = bus.R & ~r_r_prev;
  assign w_cur_code   = f_colour_code(r_mem[r_idx]);
  assign w_next_code  = f_colour_code(r_mem[w_idx_inc]);
  assign w_first_code = f_colour_code(r_mem[0]);
  assign w_hit        = (bus.B == w_cur_code);

  // GROW only acts when no higher-priority command is present in IDLE.
  assign w_grow_fire  = (r_state == S_IDLE) && !bus.CLEAR && !bus.START_1 &&
                        !bus.START_2 && bus.GROW && !r_full;

  // Sequence storage has no reset; LEN alone defines which entries are valid.
  always_ff @(posedge CLK) begin
    if (w_grow_fire) begin
      r_mem[w_wr_addr] <= r_lfsr[1:0];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_full     <= 1'b0;
      r_idx      <= '0;
      r_ph_cnt   <= '0;
      r_timer    <= '0;
      r_lfsr     <= LFSR_SEED;
      r_r_prev   <= 1'b0;
      r_b_out    <= 3'd0;
      r_end_1    <= 1'b0;
      r_end_2    <= 1'b0;
      r_round_ok <= 1'b0;
      r_miss     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_lfsr   <= w_lfsr_next;
      r_r_prev <= bus.R;
      r_end_1  <= 1'b0;
      r_end_2  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.CLEAR) begin
            r_len  <= '0;
            r_full <= 1'b0;
          end else if (bus.START_1) begin
            r_idx    <= '0;
            r_ph_cnt <= '0;
            if (r_len == '0) begin
              r_state <= S_DONE1;
            end else begin
              // First colour goes out on this edge so it is visible for
              // exactly ON_CYCLES cycles.
              r_b_out <= w_first_code;
              r_state <= S_PLAY_ON;
            end
          end else if (bus.START_2) begin
            r_round_ok <= 1'b0;
            r_miss     <= 1'b0;
            r_timeout  <= 1'b0;
            r_idx      <= '0;
            r_timer    <= '0;
            if (r_len == '0) begin
              r_round_ok <= 1'b1;
              r_state    <= S_DONE2;
            end else begin
              r_state <= S_LISTEN;
            end
          end else if (bus.GROW && !r_full) begin
            r_len  <= r_len + c_LEN_ONE;
            r_full <= (r_len == c_LEN_PRE);
          end
        end

        S_PLAY_ON: begin
          if (r_ph_cnt == c_ON_LAST) begin
            r_ph_cnt <= '0;
            r_b_out  <= 3'd0;
            r_state  <= S_PLAY_OFF;
          end else begin
            r_ph_cnt <= r_ph_cnt + c_PH_W'(1);
          end
        end

        S_PLAY_OFF: begin
          if (r_ph_cnt == c_OFF_LAST) begin
            r_ph_cnt <= '0;
            if (w_last) begin
              r_state <= S_DONE1;
            end else begin
              r_idx   <= w_idx_inc;
              r_b_out <= w_next_code;
              r_state <= S_PLAY_ON;
            end
          end else begin
            r_ph_cnt <= r_ph_cnt + c_PH_W'(1);
          end
        end

        S_LISTEN: begin
          // A press on the expiry edge is evaluated first and wins.
          if (w_press) begin
            if (!w_hit) begin
              r_miss  <= 1'b1;
              r_state <= S_DONE2;
            end else if (w_last) begin
              r_round_ok <= 1'b1;
              r_state    <= S_DONE2;
            end else begin
              r_idx   <= w_idx_inc;
              r_timer <= '0;
            end
          end else if (r_timer == c_TMR_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_DONE2;
          end else begin
            r_timer <= r_timer + c_TMR_W'(1);
          end
        end

        S_DONE1: begin
          r_end_1 <= 1'b1;
          r_state <= S_IDLE;
        end

        S_DONE2: begin
          r_end_2 <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.END_1    = r_end_1;
  assign bus.END_2    = r_end_2;
  assign bus.B_OUT    = r_b_out;
  assign bus.ROUND_OK = r_round_ok;
  assign bus.MISS     = r_miss;
  assign bus.TIMEOUT  = r_timeout;
  assign bus.LEN      = r_len;
  assign bus.FULL     = r_full;

endmodule
`default_nettype wire

// File: tb/tb_genius_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_genius_sequencer
//  Description : Self-checking bench for genius_sequencer. Directed command
//                table, hand-written playback/listen/reset sequences and
//                randomized rounds checked against a queue-based model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_genius_sequencer;

  localparam int          MAX_LEN = 32;
  localparam int          ON      = 4;
  localparam int          OFF     = 2;
  localparam int          TMO     = 16;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          WAVE_N  = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  genius_sequencer_if #(.MAX_LEN(MAX_LEN)) bus ();

  genius_sequencer #(
    .MAX_LEN        (MAX_LEN),
    .ON_CYCLES      (ON),
    .OFF_CYCLES     (OFF),
    .TIMEOUT_CYCLES (TMO),
    .LFSR_SEED      (SEED)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_lfsr;
  int unsigned seq [$];
  logic        m_ok, m_miss, m_tmo;

  logic        r_wave [WAVE_N];
  logic [2:0]  b_wave [WAVE_N];
  int          wpos;

  typedef struct {
    logic clear;
    logic grow;
    int   exp_len;
    logic exp_full;
  } vec_t;
  vec_t vecs [10];

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [2:0] code_of(input int unsigned i);
    case (i)
      0:       return 3'd2;
      1:       return 3'd3;
      2:       return 3'd4;
      default: return 3'd6;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; the model LFSR advances whenever reset is released.
  task automatic tick();
    @(posedge clk);
    if (rst_n) m_lfsr = lfsr_step(m_lfsr);
    else       m_lfsr = SEED;
    #1;
  endtask

  task automatic idle_inputs();
    bus.START_1 = 1'b0; bus.START_2 = 1'b0; bus.GROW = 1'b0;
    bus.CLEAR   = 1'b0; bus.R       = 1'b0; bus.B    = 3'd0;
  endtask

  task automatic check_len();
    check("len", 32'(bus.LEN), 32'(seq.size()));
    check("full", 32'(bus.FULL), 32'(seq.size() == MAX_LEN));
  endtask

  task automatic idle_cmd(input logic clear, input logic grow);
    bus.CLEAR = clear; bus.GROW = grow;
    if (clear) seq.delete();
    else if (grow && seq.size() < MAX_LEN) seq.push_back(int'(m_lfsr[1:0]));
    tick();
    bus.CLEAR = 1'b0; bus.GROW = 1'b0;
  endtask

  // Playback: each stored colour ON cycles then OFF blank cycles, END_1 one
  // cycle after the last blank phase.
  task automatic run_playback(input logic also_s2);
    int n      = seq.size();
    int span   = n * (ON + OFF);
    int end_at = span + 1;
    logic [2:0] exp_b;
    bus.START_1 = 1'b1; bus.START_2 = also_s2;
    tick();
    bus.START_1 = 1'b0; bus.START_2 = 1'b0;
    for (int k = 0; k <= end_at + 1; k++) begin
      if (k > 0) tick();
      exp_b = (k < span && (k % (ON + OFF)) < ON) ? code_of(seq[k / (ON + OFF)]) : 3'd0;
      check("play", {27'd0, bus.END_2, bus.END_1, bus.B_OUT},
                    {27'd0, 1'b0, 1'(k == end_at), exp_b});
    end
    check("play_flags", {29'd0, bus.ROUND_OK, bus.MISS, bus.TIMEOUT},
                        {29'd0, m_ok, m_miss, m_tmo});
  endtask

  task automatic wave_clear();
    for (int i = 0; i < WAVE_N; i++) begin r_wave[i] = 1'b0; b_wave[i] = 3'd0; end
    wpos = 1;
  endtask

  // gap low cycles, then R high for hold cycles: rising edge seen at edge wpos+gap
  task automatic add_press(input int gap, input int hold, input logic [2:0] col);
    for (int i = 0; i < gap && wpos < WAVE_N; i++) begin b_wave[wpos] = col; wpos++; end
    for (int i = 0; i < hold && wpos < WAVE_N; i++) begin
      r_wave[wpos] = 1'b1; b_wave[wpos] = col; wpos++;
    end
  endtask

  // Walks the press waveform: each match restarts the idle allowance of
  // TMO-1 edges; a press on the expiry edge still counts.
  task automatic model_listen(output int dec, output int verdict);
    int idx  = 0;
    int last = 0;
    dec = WAVE_N; verdict = 2;
    if (seq.size() == 0) begin dec = 0; verdict = 0; return; end
    for (int k = 1; k < WAVE_N; k++) begin
      if (r_wave[k] && !r_wave[k-1]) begin
        if (b_wave[k] != code_of(seq[idx])) begin dec = k; verdict = 1; return; end
        if (idx == seq.size() - 1) begin dec = k; verdict = 0; return; end
        idx++;
        last = k;
      end else if (k - last == TMO - 1) begin
        dec = k; verdict = 2; return;
      end
    end
  endtask

  task automatic run_listen();
    int dec, verdict;
    model_listen(dec, verdict);
    bus.R = 1'b0;
    bus.START_2 = 1'b1;
    tick();
    bus.START_2 = 1'b0;
    for (int k = 1; k <= dec + 2 && k < WAVE_N; k++) begin
      bus.R = r_wave[k]; bus.B = b_wave[k];
      tick();
      check("listen", {29'd0, bus.END_1, bus.END_2, 1'(bus.B_OUT != 3'd0)},
                      {29'd0, 1'b0, 1'(k == dec + 1), 1'b0});
    end
    bus.R = 1'b0;
    m_ok = (verdict == 0); m_miss = (verdict == 1); m_tmo = (verdict == 2);
    check("verdict", {29'd0, bus.ROUND_OK, bus.MISS, bus.TIMEOUT},
                     {29'd0, m_ok, m_miss, m_tmo});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 2, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 3, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 2, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 3, 1'b0};

    idle_inputs();
    m_lfsr = SEED; m_ok = 0; m_miss = 0; m_tmo = 0;
    rst_n = 1'b0;
    tick(); tick();
    check("reset_outs", {16'd0, bus.B_OUT, bus.END_1, bus.END_2, bus.ROUND_OK,
                         bus.MISS, bus.TIMEOUT, 2'(0), bus.LEN, bus.FULL}, 32'd0);
    rst_n = 1'b1;

    // Command table: CLEAR beats GROW, GROW appends one per cycle.
    foreach (vecs[i]) begin
      idle_cmd(vecs[i].clear, vecs[i].grow);
      check("vec_len", 32'(bus.LEN), 32'(vecs[i].exp_len));
      check("vec_full", 32'(bus.FULL), 32'(vecs[i].exp_full));
    end

    // Playback of three stored colours; END_1 at edge 19.
    run_playback(1'b0);

    // Three correct presses, R held two cycles each.
    wave_clear();
    for (int i = 0; i < 3; i++) add_press(1, 2, code_of(seq[i]));
    run_listen();
    check("ok_const", {29'd0, bus.ROUND_OK, bus.MISS, bus.TIMEOUT}, 32'b100);

    // Correct first press then an illegal code.
    wave_clear();
    add_press(2, 1, code_of(seq[0]));
    add_press(1, 1, 3'd7);
    run_listen();
    check("miss_const", {29'd0, bus.ROUND_OK, bus.MISS, bus.TIMEOUT}, 32'b010);

    // No press: TIMEOUT with END_2 at edge 16.
    wave_clear();
    run_listen();
    check("tmo_const", {29'd0, bus.ROUND_OK, bus.MISS, bus.TIMEOUT}, 32'b001);

    // First press lands on the expiry edge and is accepted.
    wave_clear();
    add_press(TMO - 2, 1, code_of(seq[0]));
    add_press(3, 1, code_of(seq[1]));
    add_press(TMO - 2, 2, code_of(seq[2]));
    run_listen();
    check("edge_const", {29'd0, bus.ROUND_OK, bus.MISS, bus.TIMEOUT}, 32'b100);

    // GROW held 40 cycles from empty saturates at MAX_LEN.
    idle_cmd(1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      idle_cmd(1'b0, 1'b1);
      check_len();
    end
    check("sat_const", {26'd0, bus.LEN}, 32'd32);
    idle_cmd(1'b1, 1'b0);
    check_len();
    run_playback(1'b0);
    run_listen();
    for (int k = 0; k < 3; k++) idle_cmd(1'b0, 1'b1);
    run_playback(1'b1);

    // Reset mid-PLAY_ON aborts immediately, no END_1 afterwards.
    bus.START_1 = 1'b1;
    tick();
    bus.START_1 = 1'b0;
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("async_rst", {26'd0, bus.B_OUT, bus.LEN}, 32'd0);
    m_lfsr = SEED; seq.delete(); m_ok = 0; m_miss = 0; m_tmo = 0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      check("post_rst", {27'd0, bus.END_1, bus.END_2, bus.B_OUT}, 32'd0);
    end

    // Randomized rounds against the model.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          if ($urandom_range(0, 1) == 1) idle_cmd(1'b1, 1'b0);
          for (int g = $urandom_range(0, 4); g > 0; g--) idle_cmd(1'b0, 1'b1);
          check_len();
        end
        1: run_playback(1'($urandom_range(0, 1)));
        default: begin
          int np;
          wave_clear();
          np = $urandom_range(0, seq.size() + 1);
          for (int i = 0; i < np; i++) begin
            logic [2:0] col;
            if (i < seq.size() && $urandom_range(0, 9) < 8) col = code_of(seq[i]);
            else col = 3'($urandom_range(0, 7));
            add_press((i == 0) ? $urandom_range(0, TMO) : $urandom_range(1, TMO),
                      $urandom_range(1, 3), col);
          end
          run_listen();
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/genius_sequencer.md
Name: genius_sequencer

Overview:
- Responder side of the game controller's START/END handshake. Stores the growing Simon colour sequence and generates new random colours.
- START_1 plays the stored sequence back on B_OUT for the VGA/LED layer, then returns END_1.
- START_2 opens the player-input window, checks the presses against the stored sequence, and returns END_2 with a verdict.
- Sits between the genius controller FSM and the genius_vga sprite block.

Parameters:
MAX_LEN, 32, maximum sequence length (≥1)
ON_CYCLES, 4, cycles each colour is shown during playback (≥1)
OFF_CYCLES, 2, blank cycles after each colour (≥1)
TIMEOUT_CYCLES, 16, idle cycles allowed between player presses (≥2)
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
START_1  in  1  request playback (level, sampled in IDLE)
START_2  in  1  request input window (level, sampled in IDLE)
GROW  in  1  append one random colour (sampled in IDLE)
CLEAR  in  1  empty the sequence (sampled in IDLE)
R  in  1  player press strobe; may be held for many cycles
B  in  3  pressed colour code, valid with R
END_1  out  1  one-cycle pulse: playback complete
END_2  out  1  one-cycle pulse: input window closed
B_OUT  out  3  colour being played; 0 = blank
ROUND_OK  out  1  whole sequence matched
MISS  out  1  wrong colour pressed
TIMEOUT  out  1  player too slow
LEN  out  $clog2(MAX_LEN+1)  current sequence length
FULL  out  1  LEN == MAX_LEN

Behaviour:
- Colour index map (2-bit index to 3-bit code): 0→GREEN=2, 1→RED=3, 2→BLUE=4, 3→YELLOW=6. Codes 0, 1, 5 and 7 never match.
- Reset (RESET=0, async): state IDLE, LEN=0, B_OUT=0, all END and flag outputs 0, LFSR=LFSR_SEED, press-edge register=0. Asserting reset mid-operation aborts it with no END pulse. Memory contents are don't-care.
- All outputs are registered.
- LFSR: 16-bit Galois, mask 16'hB400. Advances every cycle, including outside IDLE. The new colour index is lfsr[1:0].
- States: IDLE, PLAY_ON, PLAY_OFF, LISTEN, DONE1, DONE2.
- IDLE command priority in the same cycle: CLEAR > START_1 > START_2 > GROW. Only one command acts per cycle. All commands are ignored outside IDLE.
- CLEAR: LEN←0 next cycle.
- GROW: mem[LEN]←lfsr[1:0], LEN←LEN+1. Ignored when FULL. Holding GROW high appends one colour per cycle.
- START_1 with LEN>0:
  - idx←0, enter PLAY_ON.
  - PLAY_ON: B_OUT=code(mem[idx]) for ON_CYCLES cycles.
  - PLAY_OFF: B_OUT=0 for OFF_CYCLES cycles; then idx++.
  - After the last colour's OFF phase, enter DONE1: END_1=1 for exactly one cycle, then IDLE.
  - END_1 asserts LEN*(ON_CYCLES+OFF_CYCLES)+1 cycles after the START_1 sampling edge.
- START_1 with LEN=0: DONE1 on the next cycle.
- START_2:
  - Clear ROUND_OK, MISS and TIMEOUT. idx←0, timer←0, enter LISTEN. B_OUT stays 0.
  - Press = rising edge of R, detected against a registered copy of R. A held R counts once.
  - Press with B==code(mem[idx]) and idx==LEN-1: ROUND_OK←1, enter DONE2.
  - Press with a match and idx<LEN-1: idx++, timer←0.
  - Press with a mismatch: MISS←1, enter DONE2.
  - No press: timer++. When timer reaches TIMEOUT_CYCLES-1, set TIMEOUT←1 and enter DONE2.
  - A press in the same cycle as the timeout boundary wins; no TIMEOUT.
  - LEN=0: ROUND_OK←1, DONE2 on the next cycle.
- DONE2: END_2=1 for one cycle, then IDLE.
- ROUND_OK, MISS and TIMEOUT hold until the next START_2 or reset. Exactly one of them is set after any END_2.
- A START that is still high when returning to IDLE restarts the operation (level-sensitive). The controller must drop START on seeing END.

Test Plan:
- Reset, then GROW ×3 on consecutive cycles → LEN=1,2,3 with FULL=0. With seed ACE1, the stored indices equal the LFSR model's [1:0] bits at each grow edge.
- LEN=3, START_1 one cycle → B_OUT shows each stored code for 4 cycles followed by 0 for 2 cycles, three times. END_1 pulses for one cycle 19 cycles after the START_1 edge, then state is IDLE.
- LEN=3, START_2, then three correct presses with R held 2 cycles each → END_2 pulse with ROUND_OK=1, MISS=0, TIMEOUT=0. No double-count from the held R.
- LEN=3, START_2, correct first press then B=7 → END_2 with MISS=1. A second scenario with no press → TIMEOUT=1 and END_2 16 cycles after START_2. A press landing exactly on cycle 15 is accepted.
- GROW held for 40 cycles from LEN=0 → LEN saturates at 32 with FULL=1. CLEAR → LEN=0. START_1 at LEN=0 → END_1 on the next cycle. START_1 and START_2 together → playback only.
- RESET pulsed low mid-PLAY_ON → B_OUT=0 and LEN=0 asynchronously, with no END_1 pulse afterwards.
